// File: rtl/iob_reg_pipe_pkg.sv
// iob_reg_pipe_pkg: shared defaults for the elastic pipeline register
package iob_reg_pipe_pkg;
    localparam int          IOB_REG_PIPE_DATA_W  = 32;
    localparam int          IOB_REG_PIPE_DEPTH   = 2;
    localparam logic [31:0] IOB_REG_PIPE_RST_VAL = '0;
endpackage

// File: rtl/iob_reg_pipe_stage.sv
// iob_reg_pipe_stage: one valid/data slot of the elastic pipeline
module iob_reg_pipe_stage
    import iob_reg_pipe_pkg::*;
#(
    parameter int                DATA_W  = IOB_REG_PIPE_DATA_W,
    parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(IOB_REG_PIPE_RST_VAL)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke,
    input  logic              rst,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic              dn_ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              ready
);
    assign ready = !valid | dn_ready;
    // slot refills when empty or when its beat moves on; data holds across bubbles
    always_ff @(posedge clk_i or negedge arst_n_i)
        if (!arst_n_i) begin
            valid <= 1'b0;
            data  <= RST_VAL;
        end else if (cke && rst) begin
            valid <= 1'b0;
            data  <= RST_VAL;
        end else if (cke && ready) begin
            valid <= up_valid;
            if (up_valid) data <= up_data;
        end
endmodule

// File: rtl/iob_reg_pipe.sv
// iob_reg_pipe: DEPTH-stage elastic valid/ready pipeline register with occupancy count
module iob_reg_pipe
    import iob_reg_pipe_pkg::*;
#(
    parameter int                DATA_W  = IOB_REG_PIPE_DATA_W,
    parameter int                DEPTH   = IOB_REG_PIPE_DEPTH,
    parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(IOB_REG_PIPE_RST_VAL),
    localparam int               LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               cke_i,
    input  logic               rst_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [DATA_W-1:0]  s_data_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [DATA_W-1:0]  m_data_o,
    output logic [LEVEL_W-1:0] level_o
);
    logic in_xfer, out_xfer;
    for (genvar k = 0; k < DEPTH; k++) begin : g
        logic              vld, rdy, up_v, dn_r;
        logic [DATA_W-1:0] dat, up_d;
        if (k == 0) begin : g_src
            assign up_v = s_valid_i;
            assign up_d = s_data_i;
        end else begin : g_mid
            assign up_v = g[k-1].vld;
            assign up_d = g[k-1].dat;
        end
        if (k == DEPTH - 1) begin : g_snk
            assign dn_r = m_ready_i;
        end else begin : g_fwd
            assign dn_r = g[k+1].rdy;
        end
        iob_reg_pipe_stage #(
            .DATA_W  (DATA_W),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk_i    (clk_i),
            .arst_n_i (arst_n_i),
            .cke      (cke_i),
            .rst      (rst_i),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (dn_r),
            .valid    (vld),
            .data     (dat),
            .ready    (rdy)
        );
    end
    assign s_ready_o = cke_i & g[0].rdy;
    assign m_valid_o = cke_i & g[DEPTH-1].vld;
    assign m_data_o  = g[DEPTH-1].dat;
    assign in_xfer   = s_valid_i & s_ready_o;
    assign out_xfer  = m_valid_o & m_ready_i;
    // occupancy = accepted minus delivered beats; freezes and clears with the stages
    always_ff @(posedge clk_i or negedge arst_n_i)
        if (!arst_n_i) level_o <= '0;
        else if (cke_i) level_o <= rst_i ? '0 : level_o + LEVEL_W'(in_xfer) - LEVEL_W'(out_xfer);
endmodule

// File: tb/tb_iob_reg_pipe.sv
// tb_iob_reg_pipe: directed and random checks of iob_reg_pipe against a FIFO scoreboard
module tb_iob_reg_pipe;
    localparam int         DW = 8;
    localparam int         D  = 3;
    localparam logic [7:0] RV = 8'h5A;
    logic          clk_i = 0, arst_n_i = 0, cke_i = 1, rst_i = 0, s_valid_i = 0, m_ready_i = 0;
    logic [DW-1:0] s_data_i = '0;
    logic          s_ready_o, m_valid_o;
    logic [DW-1:0] m_data_o;
    logic [1:0]    level_o;
    int            checks = 0, errors = 0;
    logic [DW-1:0] q [$];
    logic [DW-1:0] t2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [DW-1:0] t4 [3] = '{8'hB0, 8'hC0, 8'hD0};

    always #5 clk_i = ~clk_i;

    iob_reg_pipe #(.DATA_W(DW), .DEPTH(D), .RST_VAL(RV)) dut (
        .clk_i     (clk_i),
        .arst_n_i  (arst_n_i),
        .cke_i     (cke_i),
        .rst_i     (rst_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .level_o   (level_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // scoreboard: in-order FIFO of accepted beats; occupancy and ready follow from its size
    always @(negedge clk_i) if (arst_n_i) begin
        check("level", level_o, q.size());
        check("s_ready", s_ready_o, cke_i & ((q.size() < D) | m_ready_i));
        if (!cke_i) check("m_valid_frozen", m_valid_o, 0);
        if (m_valid_o) check("m_valid_nonempty", q.size() != 0, 1);
        if (cke_i && rst_i) q.delete();
        else if (cke_i) begin
            if (m_valid_o && m_ready_i && q.size() != 0) check("m_data", m_data_o, q.pop_front());
            if (s_valid_i && s_ready_o) q.push_back(s_data_i);
        end
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #2;
        check("arst_mv", m_valid_o, 0);
        check("arst_md", m_data_o, RV);
        check("arst_lv", level_o, 0);
        check("arst_sr", s_ready_o, 1);
        @(negedge clk_i);
        arst_n_i = 1;
        m_ready_i = 1;
        for (int j = 1; j <= 13; j++) begin
            s_valid_i = j <= 10;
            s_data_i = 8'(j);
            tick();
            check("t1_mv", m_valid_o, j >= 3 && j <= 12);
            if (j >= 3 && j <= 12) check("t1_md", m_data_o, j - 2);
            check("t1_lv", level_o, (j <= 10 ? j : 10) - (j > 3 ? j - 3 : 0));
        end
        m_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            s_valid_i = 1;
            s_data_i = t2[i];
            tick();
        end
        check("t2_full_lv", level_o, 3);
        check("t2_full_sr", s_ready_o, 0);
        check("t2_full_mv", m_valid_o, 1);
        check("t2_full_md", m_data_o, 8'h11);
        m_ready_i = 1;
        tick();
        s_valid_i = 0;
        for (int i = 1; i < 4; i++) begin
            check("t2_md", m_data_o, t2[i]);
            check("t2_mv", m_valid_o, 1);
            tick();
        end
        check("t2_lv_end", level_o, 0);
        m_ready_i = 0;
        s_valid_i = 1;
        s_data_i = 8'hA0;
        tick();
        s_valid_i = 0;
        tick();
        s_valid_i = 1;
        s_data_i = 8'hB0;
        tick();
        s_valid_i = 0;
        tick();
        check("t3_lv", level_o, 2);
        check("t3_mv", m_valid_o, 1);
        check("t3_md", m_data_o, 8'hA0);
        check("t3_sr", s_ready_o, 1);
        s_valid_i = 1;
        s_data_i = 8'hC0;
        tick();
        check("t4_full_lv", level_o, 3);
        s_data_i = 8'hD0;
        cke_i = 0;
        for (int i = 0; i < 5; i++) begin
            rst_i = i == 2;
            tick();
            check("t4_frz_mv", m_valid_o, 0);
            check("t4_frz_sr", s_ready_o, 0);
            check("t4_frz_lv", level_o, 3);
            check("t4_frz_md", m_data_o, 8'hA0);
        end
        rst_i = 0;
        cke_i = 1;
        m_ready_i = 1;
        tick();
        s_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            check("t4_md", m_data_o, t4[i]);
            tick();
        end
        check("t4_lv_end", level_o, 0);
        m_ready_i = 0;
        s_valid_i = 1;
        s_data_i = 8'h01;
        tick();
        s_data_i = 8'h02;
        tick();
        check("t5_pre_lv", level_o, 2);
        s_data_i = 8'h03;
        rst_i = 1;
        tick();
        rst_i = 0;
        s_valid_i = 0;
        check("t5_lv", level_o, 0);
        check("t5_mv", m_valid_o, 0);
        check("t5_md", m_data_o, RV);
        tick();
        check("t5_lv_after", level_o, 0);
        m_ready_i = 1;
        for (int i = 0; i < 5; i++) begin
            s_valid_i = 1;
            s_data_i = 8'($urandom);
            tick();
        end
        #1;
        arst_n_i = 0;
        q.delete();
        #1;
        check("t6_mv", m_valid_o, 0);
        check("t6_md", m_data_o, RV);
        check("t6_lv", level_o, 0);
        s_valid_i = 0;
        @(negedge clk_i);
        arst_n_i = 1;
        for (int i = 0; i < 3000; i++) begin
            s_valid_i = 1'($urandom_range(0, 1));
            s_data_i = 8'($urandom);
            m_ready_i = $urandom_range(0, 3) != 0;
            cke_i = $urandom_range(0, 7) != 0;
            rst_i = $urandom_range(0, 63) == 0;
            tick();
        end
        cke_i = 1;
        rst_i = 0;
        s_valid_i = 0;
        m_ready_i = 1;
        repeat (D + 1) tick();
        check("drain_lv", level_o, 0);
        check("drain_mv", m_valid_o, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
